// File: rtl/usb_uart_stream_bridge.sv
// usb_uart byte port to valid/ready RX/TX byte streams.
// One usb_uart op in flight; reads and writes alternate when both are possible.
module usb_uart_stream_bridge #(
  parameter int RX_DEPTH   = 16,
  parameter int TX_DEPTH   = 16,
  parameter int RD_TIMEOUT = 255
) (
  input  logic                        clk_48mhz,
  input  logic                        resetn,
  output logic                        uart_re,
  output logic                        uart_we,
  output logic [7:0]                  uart_di,
  input  logic [7:0]                  uart_do,
  input  logic                        uart_wait,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [$clog2(RX_DEPTH):0]   rx_level,
  output logic [$clog2(TX_DEPTH):0]   tx_level
);

  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RLW = RAW + 1;
  localparam int TLW = TAW + 1;
  localparam int RRW = RLW + 1;
  localparam int TW  = $clog2(RD_TIMEOUT + 1);

  localparam logic [RLW-1:0] RX_FULL  = RLW'(RX_DEPTH);
  localparam logic [TLW-1:0] TX_FULL  = TLW'(TX_DEPTH);
  localparam logic [RRW-1:0] RX_LIMIT = RRW'(RX_DEPTH);
  localparam logic [TW-1:0]  TIMEOUT  = TW'(RD_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    RD_REQ,
    RD_CAP,
    WR_REQ
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            last_rd_q, last_rd_d;

  logic [7:0]      rx_mem [RX_DEPTH];
  logic [RAW-1:0]  rx_wp_q, rx_wp_d;
  logic [RAW-1:0]  rx_rp_q, rx_rp_d;
  logic [RLW-1:0]  rx_lvl_q, rx_lvl_d;

  logic [7:0]      tx_mem [TX_DEPTH];
  logic [TAW-1:0]  tx_wp_q, tx_wp_d;
  logic [TAW-1:0]  tx_rp_q, tx_rp_d;
  logic [TLW-1:0]  tx_lvl_q, tx_lvl_d;

  logic            rx_push, rx_pop;
  logic            tx_push, tx_pop;
  logic            rd_ok, wr_ok;
  logic [RRW-1:0]  rx_resv;
  logic [TW-1:0]   timer_inc;
  logic [7:0]      tx_head;

  assign rx_push  = (state_q == RD_CAP);
  assign rx_valid = (rx_lvl_q != '0);
  assign rx_pop   = rx_valid && rx_ready;
  assign rx_data  = rx_mem[rx_rp_q];
  assign rx_level = rx_lvl_q;

  // A write completing this cycle frees a slot for a same-cycle push.
  assign tx_pop   = (state_q == WR_REQ) && !uart_wait;
  assign tx_ready = (tx_lvl_q != TX_FULL) || tx_pop;
  assign tx_push  = tx_valid && tx_ready;
  assign tx_head  = tx_mem[tx_rp_q];
  assign tx_level = tx_lvl_q;

  assign uart_re  = (state_q == RD_REQ);
  assign uart_we  = (state_q == WR_REQ);
  assign uart_di  = uart_we ? tx_head : 8'h00;

  assign rx_resv   = {1'b0, rx_lvl_q} + RRW'(rx_push);
  assign rd_ok     = (rx_resv < RX_LIMIT);
  assign wr_ok     = (tx_lvl_q != '0);
  assign timer_inc = timer_q + TW'(1);

  always_comb begin
    rx_wp_d  = rx_wp_q;
    rx_rp_d  = rx_rp_q;
    rx_lvl_d = rx_lvl_q;
    if (rx_push) rx_wp_d = rx_wp_q + RAW'(1);
    if (rx_pop)  rx_rp_d = rx_rp_q + RAW'(1);
    if (rx_push && !rx_pop) rx_lvl_d = rx_lvl_q + RLW'(1);
    if (!rx_push && rx_pop) rx_lvl_d = rx_lvl_q - RLW'(1);
  end

  always_comb begin
    tx_wp_d  = tx_wp_q;
    tx_rp_d  = tx_rp_q;
    tx_lvl_d = tx_lvl_q;
    if (tx_push) tx_wp_d = tx_wp_q + TAW'(1);
    if (tx_pop)  tx_rp_d = tx_rp_q + TAW'(1);
    if (tx_push && !tx_pop) tx_lvl_d = tx_lvl_q + TLW'(1);
    if (!tx_push && tx_pop) tx_lvl_d = tx_lvl_q - TLW'(1);
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    last_rd_d = last_rd_q;
    unique case (state_q)
      IDLE: begin
        if (rd_ok && !(wr_ok && last_rd_q)) begin
          state_d = RD_REQ;
          timer_d = '0;
        end else if (wr_ok) begin
          state_d = WR_REQ;
        end
      end
      RD_REQ: begin
        if (!uart_wait) begin
          state_d = RD_CAP;
        end else if (wr_ok) begin
          // A stalled read only gives way when a write is waiting.
          timer_d = timer_inc;
          if (timer_inc == TIMEOUT) begin
            state_d   = IDLE;
            last_rd_d = 1'b1;
          end
        end
      end
      RD_CAP: begin
        state_d   = IDLE;
        last_rd_d = 1'b1;
      end
      WR_REQ: begin
        if (!uart_wait) begin
          state_d   = IDLE;
          last_rd_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_48mhz) begin
    if (rx_push) rx_mem[rx_wp_q] <= uart_do;
    if (tx_push) tx_mem[tx_wp_q] <= tx_data;
  end

  always_ff @(posedge clk_48mhz) begin
    if (!resetn) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      last_rd_q <= 1'b0;
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      rx_lvl_q  <= '0;
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      tx_lvl_q  <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      last_rd_q <= last_rd_d;
      rx_wp_q   <= rx_wp_d;
      rx_rp_q   <= rx_rp_d;
      rx_lvl_q  <= rx_lvl_d;
      tx_wp_q   <= tx_wp_d;
      tx_rp_q   <= tx_rp_d;
      tx_lvl_q  <= tx_lvl_d;
    end
  end

endmodule
